// File: rtl/dac_spi_serializer_pkg.sv
// Shared types and helpers for the dual-channel DAC SPI serializer.
// Combinational only: no latency, no backpressure.
package dac_pkg;

  localparam int DAC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int MID_CODE   = 2048;

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP_A,
    FRAME_B,
    GAP_B,
    LDAC
  } dac_state_t;

  // Signed sample to offset-binary DAC code, clamped to the 12-bit range.
  function automatic logic [DAC_BITS-1:0] sat_to_code(input logic signed [15:0] sample);
    logic signed [16:0] sum;
    sum = 17'(sample) + 17'(MID_CODE);
    if (sum < 17'sd0) begin
      return '0;
    end else if (sum > 17'sd4095) begin
      return '1;
    end else begin
      return sum[DAC_BITS-1:0];
    end
  endfunction

  function automatic logic [FRAME_BITS-1:0] frame_word(input logic                sel,
                                                       input logic                buf_bit,
                                                       input logic                ga_n,
                                                       input logic                shdn_n,
                                                       input logic [DAC_BITS-1:0] code);
    return {sel, buf_bit, ga_n, shdn_n, code};
  endfunction

endpackage

// File: rtl/dac_spi_serializer_shift.sv
// Mode-0 SPI shifter: one 16-bit word MSB first, 32*CLK_DIV cycles from start to done.
// No backpressure: start is only issued by the sequencer while the shifter is idle.
module spi_shift16
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  sclk,
  output logic                  sdi,
  output logic                  done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]            div_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  active;
  logic                  tick;

  assign tick = active && (div_cnt == DIV_LAST);
  // done coincides with the 16th falling edge so the sequencer leaves the frame on that edge
  assign done = tick && sclk && (bit_cnt == 4'd15);
  assign sdi  = active & shreg[FRAME_BITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
    end else if (start) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= word;
      active  <= 1'b1;
      sclk    <= 1'b0;
    end else if (active) begin
      if (tick) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (sclk) begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            active <= 1'b0;
          end
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/dac_spi_serializer.sv
// Captures two samples, sends them as two SPI frames to a dual DAC, then pulses LDAC; 70*CLK_DIV busy cycles.
// No backpressure: a sample_valid arriving while busy is dropped and flagged in the sticky overrun bit.
module dac_spi_serializer
  import dac_pkg::*;
#(
  parameter int   CLK_DIV = 2,
  parameter logic GA_N    = 1'b1,
  parameter logic BUF     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample_a,
  input  logic [15:0] sample_b,
  input  logic [1:0]  run,
  input  logic        sample_valid,
  input  logic        overrun_clr,
  output logic        busy,
  output logic        overrun,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdi,
  output logic        ldac_n
);

  localparam logic [8:0] PHASE_LAST = 9'(2 * CLK_DIV - 1);

  dac_state_t            state;
  dac_state_t            state_nxt;
  logic [8:0]            phase_cnt;
  logic [FRAME_BITS-1:0] word_a_nxt;
  logic [FRAME_BITS-1:0] word_b_nxt;
  logic [FRAME_BITS-1:0] word_b_q;
  logic [FRAME_BITS-1:0] shift_word;
  logic                  shift_start;
  logic                  shift_done;
  logic                  phase_end;

  assign word_a_nxt = frame_word(1'b0, BUF, GA_N, run[0], sat_to_code(sample_a));
  assign word_b_nxt = frame_word(1'b1, BUF, GA_N, run[1], sat_to_code(sample_b));
  assign phase_end  = (phase_cnt == PHASE_LAST);

  // Frame A loads straight from the inputs so bit 15 is on sdi the cycle cs_n falls.
  always_comb begin
    state_nxt   = state;
    shift_start = 1'b0;
    shift_word  = word_b_q;
    unique case (state)
      IDLE: begin
        if (sample_valid) begin
          state_nxt   = FRAME_A;
          shift_start = 1'b1;
          shift_word  = word_a_nxt;
        end
      end
      FRAME_A: if (shift_done) state_nxt = GAP_A;
      GAP_A: begin
        if (phase_end) begin
          state_nxt   = FRAME_B;
          shift_start = 1'b1;
        end
      end
      FRAME_B: if (shift_done) state_nxt = GAP_B;
      GAP_B:   if (phase_end) state_nxt = LDAC;
      LDAC:    if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      word_b_q  <= '0;
      busy      <= 1'b0;
      cs_n      <= 1'b1;
      ldac_n    <= 1'b1;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= (state_nxt != state) ? 9'd0 : phase_cnt + 9'd1;
      if ((state == IDLE) && sample_valid) begin
        word_b_q <= word_b_nxt;
      end
      busy   <= (state_nxt != IDLE);
      cs_n   <= !((state_nxt == FRAME_A) || (state_nxt == FRAME_B));
      ldac_n <= (state_nxt != LDAC);
      // a new overrun wins over a simultaneous clear
      if (sample_valid && busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  spi_shift16 #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk  (clk),
    .rst_n(rst_n),
    .start(shift_start),
    .word (shift_word),
    .sclk (sclk),
    .sdi  (sdi),
    .done (shift_done)
  );

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: three builds (CLK_DIV 2, 1, 255) with a frame-decoding monitor.
module tb_dac_spi_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sa [3];
  logic [15:0] sb [3];
  logic [1:0]  rn [3];
  logic        sv [3];
  logic        oc [3];
  logic        busy_w [3];
  logic        ovr_w [3];
  logic        cs_w [3];
  logic        sclk_w [3];
  logic        sdi_w [3];
  logic        ldac_w [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dac_spi_serializer #(.CLK_DIV(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .sample_a(sa[0]), .sample_b(sb[0]), .run(rn[0]),
    .sample_valid(sv[0]), .overrun_clr(oc[0]), .busy(busy_w[0]), .overrun(ovr_w[0]),
    .cs_n(cs_w[0]), .sclk(sclk_w[0]), .sdi(sdi_w[0]), .ldac_n(ldac_w[0]));

  dac_spi_serializer #(.CLK_DIV(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .sample_a(sa[1]), .sample_b(sb[1]), .run(rn[1]),
    .sample_valid(sv[1]), .overrun_clr(oc[1]), .busy(busy_w[1]), .overrun(ovr_w[1]),
    .cs_n(cs_w[1]), .sclk(sclk_w[1]), .sdi(sdi_w[1]), .ldac_n(ldac_w[1]));

  dac_spi_serializer #(.CLK_DIV(255)) u_d255 (
    .clk(clk), .rst_n(rst_n), .sample_a(sa[2]), .sample_b(sb[2]), .run(rn[2]),
    .sample_valid(sv[2]), .overrun_clr(oc[2]), .busy(busy_w[2]), .overrun(ovr_w[2]),
    .cs_n(cs_w[2]), .sclk(sclk_w[2]), .sdi(sdi_w[2]), .ldac_n(ldac_w[2]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  r;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  typedef struct {
    logic [15:0] fr [2];
    int          rises [2];
    int          cs_low [2];
    int          ldac;
    int          busy;
    int          period;
    bit          timeout;
  } cap_t;

  function automatic int dval(input int idx);
    return (idx == 0) ? 2 : (idx == 1) ? 1 : 255;
  endfunction

  // Reference: offset-binary with clamping, framed with gain 1x, unbuffered VREF.
  function automatic logic [15:0] model_word(input int sel, input int shdn, input logic [15:0] s);
    int v;
    v = $signed(s) + 2048;
    if (v < 0) v = 0;
    if (v > 4095) v = 4095;
    return 16'(sel * 32768 + 8192 + shdn * 4096 + v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at a negedge, strobes one transaction and decodes the bus until busy drops.
  task automatic run_txn(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] r, input int inj_at, input bit inj_clr,
                         output cap_t c);
    int   fi;
    int   first_rise;
    logic prev_cs;
    logic prev_sclk;
    int   limit;
    for (int k = 0; k < 2; k++) begin
      c.fr[k] = '0; c.rises[k] = 0; c.cs_low[k] = 0;
    end
    c.ldac = 0; c.busy = 0; c.period = 0; c.timeout = 1'b1;
    limit = 70 * dval(idx) + 64;
    sa[idx] = a; sb[idx] = b; rn[idx] = r; sv[idx] = 1'b1;
    @(negedge clk);
    sv[idx] = 1'b0;
    fi = 0; first_rise = -1; prev_cs = 1'b1; prev_sclk = 1'b0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (cyc == inj_at) begin
        sv[idx] = 1'b1; oc[idx] = inj_clr;
        sa[idx] = 16'h1234; sb[idx] = 16'h4321; rn[idx] = 2'b00;
      end else begin
        sv[idx] = 1'b0; oc[idx] = 1'b0;
      end
      if (!busy_w[idx]) begin
        c.timeout = 1'b0;
        break;
      end
      c.busy++;
      if (!ldac_w[idx]) c.ldac++;
      if (!cs_w[idx]) begin
        c.cs_low[fi]++;
        if (sclk_w[idx] && !prev_sclk) begin
          c.rises[fi]++;
          c.fr[fi] = {c.fr[fi][14:0], sdi_w[idx]};
          if (fi == 0 && c.rises[0] == 1) first_rise = cyc;
          if (fi == 0 && c.rises[0] == 2) c.period = cyc - first_rise;
        end
      end
      if (cs_w[idx] && !prev_cs && fi == 0) fi = 1;
      prev_cs = cs_w[idx];
      prev_sclk = sclk_w[idx];
      @(negedge clk);
    end
    sv[idx] = 1'b0; oc[idx] = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int idx, input cap_t c,
                           input logic [15:0] ea, input logic [15:0] eb);
    int d;
    d = dval(idx);
    chk({tag, ".timeout"}, int'(c.timeout), 0);
    chk({tag, ".frame_a"}, int'(c.fr[0]), int'(ea));
    chk({tag, ".frame_b"}, int'(c.fr[1]), int'(eb));
    chk({tag, ".rises_a"}, c.rises[0], 16);
    chk({tag, ".rises_b"}, c.rises[1], 16);
    chk({tag, ".cs_low_a"}, c.cs_low[0], 32 * d);
    chk({tag, ".cs_low_b"}, c.cs_low[1], 32 * d);
    chk({tag, ".ldac_low"}, c.ldac, 2 * d);
    chk({tag, ".busy"}, c.busy, 70 * d);
    chk({tag, ".bit_period"}, c.period, 2 * d);
  endtask

  vec_t vt [7];
  cap_t cap;

  initial begin
    vt[0] = '{16'h0000, 16'hF800, 2'b11, 16'h3800, 16'hB000};
    vt[1] = '{16'd3000, 16'hEC78, 2'b11, 16'h3FFF, 16'hB000};
    vt[2] = '{16'd100,  16'd100,  2'b01, 16'h3864, 16'hA864};
    vt[3] = '{16'h07FF, 16'hF7FF, 2'b11, 16'h3FFF, 16'hB000};
    vt[4] = '{16'h0800, 16'hF801, 2'b10, 16'h2FFF, 16'hB001};
    vt[5] = '{16'h7FFF, 16'h8000, 2'b00, 16'h2FFF, 16'hA000};
    vt[6] = '{16'hFFFF, 16'h0001, 2'b11, 16'h37FF, 16'hB801};

    for (int i = 0; i < 3; i++) begin
      sa[i] = '0; sb[i] = '0; rn[i] = '0; sv[i] = 1'b0; oc[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.cs_n", i), int'(cs_w[i]), 1);
      chk($sformatf("rst%0d.sclk", i), int'(sclk_w[i]), 0);
      chk($sformatf("rst%0d.sdi", i), int'(sdi_w[i]), 0);
      chk($sformatf("rst%0d.ldac_n", i), int'(ldac_w[i]), 1);
      chk($sformatf("rst%0d.busy", i), int'(busy_w[i]), 0);
      chk($sformatf("rst%0d.overrun", i), int'(ovr_w[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(0, vt[i].a, vt[i].b, vt[i].r, -1, 1'b0, cap);
      check_txn($sformatf("vec%0d", i), 0, cap, vt[i].ea, vt[i].eb);
    end

    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  r;
      if (i % 2 == 0) begin
        a = 16'($urandom_range(0, 8191) - 4096);
        b = 16'($urandom_range(0, 8191) - 4096);
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      r = 2'($urandom);
      run_txn(0, a, b, r, -1, 1'b0, cap);
      check_txn($sformatf("rnd%0d", i), 0, cap,
                model_word(0, int'(r[0]), a), model_word(1, int'(r[1]), b));
    end
    chk("overrun_quiet", int'(ovr_w[0]), 0);

    run_txn(0, vt[0].a, vt[0].b, vt[0].r, 10, 1'b0, cap);
    check_txn("ovr_inflight", 0, cap, vt[0].ea, vt[0].eb);
    chk("overrun_set", int'(ovr_w[0]), 1);
    oc[0] = 1'b1;
    @(negedge clk);
    oc[0] = 1'b0;
    chk("overrun_clr", int'(ovr_w[0]), 0);

    run_txn(0, vt[2].a, vt[2].b, vt[2].r, 10, 1'b1, cap);
    check_txn("ovr_coincident", 0, cap, vt[2].ea, vt[2].eb);
    chk("overrun_set_wins", int'(ovr_w[0]), 1);
    oc[0] = 1'b1;
    @(negedge clk);
    oc[0] = 1'b0;

    run_txn(0, vt[1].a, vt[1].b, vt[1].r, -1, 1'b0, cap);
    check_txn("b2b_first", 0, cap, vt[1].ea, vt[1].eb);
    run_txn(0, vt[6].a, vt[6].b, vt[6].r, -1, 1'b0, cap);
    check_txn("b2b_second", 0, cap, vt[6].ea, vt[6].eb);
    chk("b2b_no_overrun", int'(ovr_w[0]), 0);

    // Async reset while frame B is on the wire.
    sa[0] = vt[0].a; sb[0] = vt[0].b; rn[0] = vt[0].r; sv[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0;
    repeat (75) @(negedge clk);
    chk("midb.cs_low_before", int'(cs_w[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midb.cs_n", int'(cs_w[0]), 1);
    chk("midb.sclk", int'(sclk_w[0]), 0);
    chk("midb.sdi", int'(sdi_w[0]), 0);
    chk("midb.ldac_n", int'(ldac_w[0]), 1);
    chk("midb.busy", int'(busy_w[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(0, vt[3].a, vt[3].b, vt[3].r, -1, 1'b0, cap);
    check_txn("after_reset", 0, cap, vt[3].ea, vt[3].eb);

    run_txn(1, vt[0].a, vt[0].b, vt[0].r, -1, 1'b0, cap);
    check_txn("d1_vec0", 1, cap, vt[0].ea, vt[0].eb);
    begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom_range(0, 4095));
      run_txn(1, a, b, 2'b11, -1, 1'b0, cap);
      check_txn("d1_rnd", 1, cap, model_word(0, 1, a), model_word(1, 1, b));
    end

    run_txn(2, vt[2].a, vt[2].b, vt[2].r, -1, 1'b0, cap);
    check_txn("d255_vec2", 2, cap, vt[2].ea, vt[2].eb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_serializer.md
Name: dac_spi_serializer

Overview:
- Downstream consumer of the dual-channel DC/waveform sample generator.
- Takes one signed 16-bit sample per channel (A, B) on a valid strobe.
- Converts each sample to 12-bit offset-binary with saturation.
- Shifts both words out as two 16-bit SPI frames to an MCP4922-style dual DAC, then pulses LDAC so both outputs update simultaneously.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period (D); legal range 1..255.
- GA_N, 1: value driven on the DAC gain bit (1 = 1x gain).
- BUF, 0: value driven on the DAC VREF-buffer bit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_a  input  16  signed sample, channel A.
- sample_b  input  16  signed sample, channel B.
- run  input  2  run[0] = channel A enable, run[1] = channel B enable; sampled with the samples.
- sample_valid  input  1  one-cycle strobe; samples and run are captured when it is high and the block is idle.
- overrun_clr  input  1  clears the overrun flag.
- busy  output  1  high while a transaction is in progress.
- overrun  output  1  sticky; set when sample_valid arrives while busy.
- cs_n  output  1  SPI chip select, active low.
- sclk  output  1  SPI clock, idle low, mode 0.
- sdi  output  1  SPI data, MSB first.
- ldac_n  output  1  DAC latch strobe, active low.

Behaviour:
- Reset values:
  - cs_n = 1, sclk = 0, sdi = 0, ldac_n = 1.
  - busy = 0, overrun = 0.
  - State = IDLE; capture registers = 0.
- Conversion: code = sample + 2048 computed at 17-bit signed width.
  - Result < 0 → 0x000; result > 4095 → 0xFFF; otherwise code[11:0].
  - Saturation happens at capture.
- Frame word: {sel, BUF, GA_N, shdn_n, code[11:0]}.
  - sel = 0 for channel A, 1 for channel B.
  - shdn_n = captured run bit for that channel.
- States and transitions (D = CLK_DIV):
  - IDLE: on sample_valid, capture both words; go to FRAME_A next cycle. busy rises the same cycle as cs_n falls, 1 cycle after the strobe.
  - FRAME_A: cs_n = 0 for 32·D cycles.
    - sdi presents bit 15 on entry.
    - sclk rises after D cycles and falls after 2·D cycles.
    - sdi advances to the next bit on each sclk falling edge.
    - After 16 rising edges and the 16th falling edge, go to GAP_A.
  - GAP_A: cs_n = 1, sclk = 0, for 2·D cycles; then FRAME_B.
  - FRAME_B: identical to FRAME_A with the B word; then GAP_B for 2·D cycles.
  - LDAC: ldac_n = 0 for 2·D cycles; then IDLE, with busy falling on entry to IDLE.
- Total busy duration is 70·D cycles; D = 2 gives 140 cycles.
- A new sample_valid may be accepted on the first IDLE cycle.
- sample_valid while busy: the sample is dropped and overrun is set.
  - In-flight frames are unaffected.
- overrun_clr:
  - Clears overrun.
  - If clear and a new overrun event occur in the same cycle, set wins.
- rst_n assertion mid-transaction forces every output to its reset value immediately (asynchronous). No partial frame resumes.
- Bit and divider counters must be wide enough for CLK_DIV = 255 without wrap errors.

Decomposition:
- Shared package dac_pkg holds:
  - state enum (IDLE, FRAME_A, GAP_A, FRAME_B, GAP_B, LDAC);
  - DAC_BITS = 12, FRAME_BITS = 16, MID_CODE = 2048;
  - function sat_to_code(signed [15:0]) returning [11:0].
- Natural sub-module: spi_shift16, which owns the divider, shift register and bit count, and returns a done pulse.
  - The top FSM sequences two spi_shift16 runs plus the gaps and the LDAC phase.

Test Plan:
- sample_a = 0, sample_b = -2048, run = 2'b11, D = 2 → frame A 0x3800, frame B 0xB000. Check 16 sclk rises per frame, cs_n low for 64 cycles each, ldac_n low for 4 cycles, busy high for 140 cycles.
- sample_a = 3000, sample_b = -5000 → frame A 0x3FFF, frame B 0xB000 (both saturated).
- run = 2'b01, sample_a = 100, sample_b = 100 → A 0x3864, B 0xA864 (shdn_n = 0 on B).
- sample_valid asserted again 10 cycles into a transaction → transaction unchanged, overrun = 1. A later overrun_clr pulse → overrun = 0. overrun_clr coincident with a new overrun → stays 1.
- rst_n pulled low mid-FRAME_B → cs_n = 1, sclk = 0, ldac_n = 1, busy = 0 within the same cycle. The next sample_valid after release gives a complete, correct two-frame transaction.
- CLK_DIV = 1 and CLK_DIV = 255 builds → bit period exactly 2 and 510 cycles; total busy 70 and 17850 cycles.
